debounce_sync: RTL
==================

Name: debounce_sync

Overview:
- Conditions one raw, asynchronous board input (push-button or slide switch) into a clean, clock-synchronous level for the gate-level logic stages (inverters, AND/OR networks) fed downstream.
- Structure: two-flop synchronizer, then a counter-qualified debounce FSM, then one-cycle edge pulses.
- Downstream combinational gates see one transition per physical press or release.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a new level; legal range >= 2; 10 ms at 50 MHz.
- CNT_WIDTH, 19, stability counter width; must satisfy 2^CNT_WIDTH >= DEBOUNCE_CYCLES.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a    input  1  raw asynchronous input from board pin.
- o    output 1  debounced, synchronized level.
- rise output 1  one-cycle pulse when o goes 0->1.
- fall output 1  one-cycle pulse when o goes 1->0.
- busy output 1  high while a candidate level change is being qualified (FSM in a WAIT state).

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: sync flops a_meta=0, a_sync=0; state=STABLE_LOW; cnt=0; o=0, rise=0, fall=0, busy=0.
- Synchronizer: a_meta <= a; a_sync <= a_meta. Only a_sync feeds the FSM; raw a never reaches the FSM or outputs.
- States: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW. o=1 in STABLE_HIGH and WAIT_LOW, else 0. busy=1 in WAIT_HIGH and WAIT_LOW.
- STABLE_LOW:
  - a_sync=1 -> WAIT_HIGH, cnt<=1.
  - else hold, cnt<=0.
- WAIT_HIGH:
  - a_sync=0 -> STABLE_LOW, cnt<=0; glitch rejected, no pulse.
  - a_sync=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HIGH, cnt<=0, rise<=1.
  - else cnt<=cnt+1.
- STABLE_HIGH and WAIT_LOW: exact mirror of the two states above with polarity inverted; accepted change pulses fall.
- rise and fall are registered, high for exactly one cycle, never both high in the same cycle.
- Latency: edge 1 is the first rising edge at which a is sampled at its new value, with a held constant from then on. o changes at edge DEBOUNCE_CYCLES+2. rise/fall assert at that same edge.
- Counter: never exceeds DEBOUNCE_CYCLES-1 and never wraps. cnt is cleared on every return to a STABLE state.
- Bounce handling: any reversion of a_sync during WAIT restarts qualification from zero. The next change re-enters WAIT with cnt=1.
- Reset mid-operation:
  - rst=1 at any edge forces all reset values on that edge, including o=0 from STABLE_HIGH and dropping any pending qualification. No fall pulse is generated by reset.
  - If a is still high after rst deasserts, o re-asserts after DEBOUNCE_CYCLES+2 edges, with rise pulsed.
  - rst has priority over every FSM transition.
- Toggle rate: one press produces exactly one rise and one release produces exactly one fall, regardless of bounce count.

Test Plan (DEBOUNCE_CYCLES=4, CNT_WIDTH=3):
- Reset: rst=1 for 2 edges with a=1 -> o=0, rise=0, fall=0, busy=0 throughout reset.
- Clean press: a 0->1 before edge 1, held -> busy=1 from edge 3; o=1 and rise=1 at edge 6; rise=0 at edge 7; busy=0 at edge 6.
- Glitch rejection: a=1 for exactly 3 edges, then 0 -> o stays 0; no rise; busy pulses high then returns to 0; cnt back to 0.
- Bounced press: a pattern 1,0,1,1,0,1 then held 1 -> exactly one rise; o rises 6 edges after the final 0->1 sample; no fall.
- Release: from o=1, a 1->0 held -> o=0 and fall=1 at edge 6 of release; single-cycle fall.
- Reset mid-WAIT and mid-HIGH: rst pulse while busy=1 -> busy=0, cnt=0 next edge. rst pulse while o=1 and a=1 -> o=0 next edge, no fall; after rst release, rise again 6 edges later.

Source files
------------

// File: rtl/debounce_sync.sv
// Conditions one raw asynchronous board input into a debounced, clock-synchronous level
// with one-cycle rise/fall pulses: 2-flop synchronizer -> counter-qualified FSM -> edge pulses.
module debounce_sync #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_WIDTH       = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic o,
    output logic rise,
    output logic fall,
    output logic busy
);

    // state       | meaning
    // STABLE_LOW  | accepted level 0, no change pending
    // WAIT_HIGH   | a_sync went 1, counting stable samples before accepting 1
    // STABLE_HIGH | accepted level 1, no change pending
    // WAIT_LOW    | a_sync went 0, counting stable samples before accepting 0
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        WAIT_HIGH   = 2'b01,
        STABLE_HIGH = 2'b11,
        WAIT_LOW    = 2'b10
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 a_meta_q;
    logic                 a_sync_q;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;

    // Only a_sync_q may be used past this point; a_meta_q can be metastable.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_meta_q <= 1'b0;
            a_sync_q <= 1'b0;
        end else begin
            a_meta_q <= a;
            a_sync_q <= a_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (a_sync_q) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!a_sync_q) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!a_sync_q) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (a_sync_q) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign o    = (state_q == STABLE_HIGH) || (state_q == WAIT_LOW);
    assign busy = (state_q == WAIT_HIGH)   || (state_q == WAIT_LOW);
    assign rise = rise_q;
    assign fall = fall_q;

`ifndef SYNTHESIS
    a_no_double_pulse : assert property (@(posedge clk) disable iff (rst) !(rise_q && fall_q));
    a_cnt_bounded     : assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_LAST);
`endif

endmodule
